psr_stack_unit: RTL and testbench

//   Save/restore sequencer for processor state on trap/interrupt entry and return.
//   On save it writes the PSR {n,z,p} and the PC to the supervisor stack in memory.
//   On restore it reads both back and presents them to the datapath.
//   psr_out/psr_load drive the ALU's mdr16/frm_mem PSR-restore path.

---
 rtl/psr_stack_unit.sv | 160 ++++++++++++++++
 tb/tb_psr_stack_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_stack_unit.sv
// Saves and restores {PSR, PC} on the supervisor stack for trap/interrupt entry and return.
// The memory side uses a request/ack handshake, and the stack pointer moves only when an operation finishes.
module psr_stack_unit #(
  parameter logic [15:0] SP_RESET    = 16'h3000,
  parameter logic [15:0] STACK_LIMIT = 16'h2F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        save_req,
  input  logic        restore_req,
  input  logic [15:0] pc_in,
  input  logic        n_in,
  input  logic        z_in,
  input  logic        p_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pc_out,
  output logic [15:0] psr_out,
  output logic        pc_load,
  output logic        psr_load,
  output logic [15:0] sp_out
);

  typedef enum logic [2:0] {IDLE, S_PSR, S_PC, R_PC, R_PSR, FIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] pc_cap_q, pc_cap_d;
  logic [2:0]  nzp_cap_q, nzp_cap_d;
  logic        restore_op_q, restore_op_d;
  logic        err_q, err_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [2:0]  psr_out_q, psr_out_d;

  logic [15:0] sp_m1, sp_m2, sp_p1, sp_p2;

  assign sp_m1 = sp_q - 16'd1;
  assign sp_m2 = sp_q - 16'd2;
  assign sp_p1 = sp_q + 16'd1;
  assign sp_p2 = sp_q + 16'd2;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    pc_cap_d     = pc_cap_q;
    nzp_cap_d    = nzp_cap_q;
    restore_op_d = restore_op_q;
    err_d        = 1'b0;
    pc_out_d     = pc_out_q;
    psr_out_d    = psr_out_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    done         = 1'b0;
    pc_load      = 1'b0;
    psr_load     = 1'b0;

    case (state_q)
      IDLE: begin
        // Save has priority; a refused request never touches memory.
        if (save_req) begin
          if (sp_m2 < STACK_LIMIT) begin
            err_d = 1'b1;
          end else begin
            state_d      = S_PSR;
            pc_cap_d     = pc_in;
            nzp_cap_d    = {n_in, z_in, p_in};
            restore_op_d = 1'b0;
          end
        end else if (restore_req) begin
          if (sp_q > SP_RESET - 16'd2) begin
            err_d = 1'b1;
          end else begin
            state_d      = R_PC;
            restore_op_d = 1'b1;
          end
        end
      end
      S_PSR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_m1;
        mem_wdata = {13'b0, nzp_cap_q};
        if (mem_ack) state_d = S_PC;
      end
      S_PC: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_m2;
        mem_wdata = pc_cap_q;
        if (mem_ack) state_d = FIN;
      end
      R_PC: begin
        mem_req  = 1'b1;
        mem_addr = sp_q;
        if (mem_ack) begin
          pc_out_d = mem_rdata;
          state_d  = R_PSR;
        end
      end
      R_PSR: begin
        mem_req  = 1'b1;
        mem_addr = sp_p1;
        if (mem_ack) begin
          psr_out_d = mem_rdata[2:0];
          state_d   = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
        if (restore_op_q) begin
          pc_load  = 1'b1;
          psr_load = 1'b1;
          sp_d     = sp_p2;
        end else begin
          sp_d = sp_m2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sp_q         <= SP_RESET;
      pc_cap_q     <= 16'h0000;
      nzp_cap_q    <= 3'b000;
      restore_op_q <= 1'b0;
      err_q        <= 1'b0;
      pc_out_q     <= 16'h0000;
      psr_out_q    <= 3'b000;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      pc_cap_q     <= pc_cap_d;
      nzp_cap_q    <= nzp_cap_d;
      restore_op_q <= restore_op_d;
      err_q        <= err_d;
      pc_out_q     <= pc_out_d;
      psr_out_q    <= psr_out_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign err     = err_q;
  assign pc_out  = pc_out_q;
  assign psr_out = {13'b0, psr_out_q};
  assign sp_out  = sp_q;

endmodule

// File: tb/tb_psr_stack_unit.sv
// Scoreboard bench for psr_stack_unit: a stack-of-frames reference model predicts memory accesses
// and completion events, while separate memory and monitor processes check them as the DUT produces them.
module tb_psr_stack_unit;

  localparam logic [15:0] SP_RESET    = 16'h3000;
  localparam logic [15:0] STACK_LIMIT = 16'h2F00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        save_req = 1'b0;
  logic        restore_req = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic        n_in = 1'b0, z_in = 1'b0, p_in = 1'b0;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        busy, done, err;
  logic [15:0] pc_out, psr_out, sp_out;
  logic        pc_load, psr_load;

  always #5 clk = ~clk;

  psr_stack_unit #(.SP_RESET(SP_RESET), .STACK_LIMIT(STACK_LIMIT)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
    .pc_in(pc_in), .n_in(n_in), .z_in(z_in), .p_in(p_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
    .pc_out(pc_out), .psr_out(psr_out), .pc_load(pc_load), .psr_load(psr_load),
    .sp_out(sp_out)
  );

  // kind: 0 = save completed, 1 = restore completed, 2 = refused
  typedef struct {int kind; logic [15:0] pc; logic [15:0] psr; logic [15:0] sp_after;} evt_t;
  typedef struct {bit we; logic [15:0] addr; logic [15:0] data;} acc_t;
  typedef struct {logic [15:0] pc; logic [2:0] nzp;} frame_t;

  evt_t        exp_evt[$];
  acc_t        exp_acc[$];
  frame_t      model_stack[$];
  logic [15:0] model_sp = SP_RESET;
  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  int max_wait = 0;
  bit rand_wait = 0;
  int cur_wait = 0;
  int wait_cnt = 0;
  int block_addr = -1;
  bit sp_pending = 0;
  logic [15:0] sp_expect = 16'h0000;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got no event, expected one", name);
  endtask

  // Reference model: a stack of frames plus a 16-bit pointer moving in steps of two
  task automatic modelIssue(input bit save, input bit restore, input logic [15:0] pc, input logic [2:0] nzp);
    evt_t e;
    acc_t a;
    frame_t f;
    e.pc = 16'h0000;
    e.psr = 16'h0000;
    if (save) begin
      if (16'(model_sp - 16'd2) < STACK_LIMIT) begin
        e.kind = 2;
      end else begin
        a.we = 1; a.addr = model_sp - 16'd1; a.data = {13'b0, nzp}; exp_acc.push_back(a);
        a.we = 1; a.addr = model_sp - 16'd2; a.data = pc;           exp_acc.push_back(a);
        f.pc = pc; f.nzp = nzp;
        model_stack.push_back(f);
        model_sp = model_sp - 16'd2;
        e.kind = 0;
      end
      e.sp_after = model_sp;
      exp_evt.push_back(e);
    end else if (restore) begin
      if (model_stack.size() == 0) begin
        e.kind = 2;
      end else begin
        f = model_stack.pop_back();
        a.we = 0; a.addr = model_sp;         a.data = 16'h0000; exp_acc.push_back(a);
        a.we = 0; a.addr = model_sp + 16'd1; a.data = 16'h0000; exp_acc.push_back(a);
        model_sp = model_sp + 16'd2;
        e.kind = 1;
        e.pc = f.pc;
        e.psr = {13'b0, f.nzp};
      end
      e.sp_after = model_sp;
      exp_evt.push_back(e);
    end
  endtask

  // Memory responder: checks every request cycle against the predicted access, acks after cur_wait cycles
  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (exp_acc.size() == 0) begin
        n_cmp++; n_bad++;
        $display("[TB] FAIL unexpected_mem_req: got req at %h, expected none", mem_addr);
      end else begin
        checkOutput("mem_we", 16'(mem_we), 16'(exp_acc[0].we));
        checkOutput("mem_addr", mem_addr, exp_acc[0].addr);
        if (exp_acc[0].we) checkOutput("mem_wdata", mem_wdata, exp_acc[0].data);
      end
      if (wait_cnt >= cur_wait && block_addr != int'(mem_addr)) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (exp_acc.size() != 0) void'(exp_acc.pop_front());
        wait_cnt = 0;
        cur_wait = rand_wait ? $urandom_range(0, max_wait) : max_wait;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
      wait_cnt = 0;
    end
  end

  // Monitor: pops the expected event whenever the DUT signals completion or refusal
  always @(negedge clk) begin
    evt_t e;
    if (!rst) begin
      if (sp_pending) begin
        checkOutput("sp_after", sp_out, sp_expect);
        sp_pending = 0;
      end
      if (done || err || pc_load || psr_load) begin
        if (exp_evt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("[TB] FAIL unexpected_event: got done=%b err=%b, expected none", done, err);
        end else begin
          e = exp_evt.pop_front();
          checkOutput("done", 16'(done), 16'(e.kind != 2));
          checkOutput("err", 16'(err), 16'(e.kind == 2));
          checkOutput("pc_load", 16'(pc_load), 16'(e.kind == 1));
          checkOutput("psr_load", 16'(psr_load), 16'(e.kind == 1));
          if (e.kind == 1) begin
            checkOutput("pc_out", pc_out, e.pc);
            checkOutput("psr_out", psr_out, e.psr);
          end
          sp_expect = e.sp_after;
          sp_pending = 1;
        end
      end
    end
  end

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_evt.delete(); exp_acc.delete(); model_stack.delete();
    model_sp = SP_RESET;
    sp_pending = 0;
  endtask

  // Issues one request, optionally pokes ignored requests while busy, returns cycles to done/err
  task automatic applyStimulus(input bit save, input bit restore, input logic [15:0] pc,
                               input logic [2:0] nzp, input int inj_pct, output int cyc);
    @(negedge clk);
    save_req = save; restore_req = restore;
    pc_in = pc; {n_in, z_in, p_in} = nzp;
    modelIssue(save, restore, pc, nzp);
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0;
    pc_in = 16'($urandom); {n_in, z_in, p_in} = 3'($urandom);
    cyc = 1;
    while (!(done || err) && cyc < 200) begin
      if (busy && $urandom_range(0, 99) < inj_pct) begin
        if ($urandom_range(0, 1) == 0) save_req = 1'b1; else restore_req = 1'b1;
      end
      @(negedge clk);
      save_req = 1'b0; restore_req = 1'b0;
      cyc++;
    end
    if (cyc >= 200) failNow("op_timeout");
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int waited;
    int r;
    bit do_save, do_rest;

    resetDut();
    checkOutput("rst_sp", sp_out, SP_RESET);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_mem_req", 16'(mem_req), 16'd0);
    checkOutput("rst_mem_addr", mem_addr, 16'd0);
    checkOutput("rst_pc_out", pc_out, 16'd0);
    checkOutput("rst_psr_out", psr_out, 16'd0);
    checkOutput("rst_flags", 16'({done, err, pc_load, psr_load, mem_we}), 16'd0);

    max_wait = 0; rand_wait = 0; cur_wait = 0;
    applyStimulus(1, 0, 16'h3050, 3'b100, 0, cyc);
    checkOutput("save_latency", 16'(cyc), 16'd3);
    checkOutput("save_sp", sp_out, 16'h2FFE);

    applyStimulus(0, 1, 16'h0000, 3'b000, 0, cyc);
    checkOutput("restore_latency", 16'(cyc), 16'd3);
    checkOutput("restore_pc_hold", pc_out, 16'h3050);
    checkOutput("restore_psr_hold", psr_out, 16'h0004);
    checkOutput("restore_sp", sp_out, SP_RESET);

    max_wait = 3; cur_wait = 3;
    applyStimulus(1, 0, 16'hBEEF, 3'b010, 0, cyc);
    checkOutput("wait3_latency", 16'(cyc), 16'd9);
    applyStimulus(0, 1, 16'h0000, 3'b000, 0, cyc);
    checkOutput("wait3_restore_latency", 16'(cyc), 16'd9);
    max_wait = 0; cur_wait = 0;

    applyStimulus(0, 1, 16'h0000, 3'b000, 0, cyc);
    checkOutput("underflow_latency", 16'(cyc), 16'd1);
    checkOutput("underflow_sp", sp_out, SP_RESET);

    applyStimulus(1, 1, 16'h1111, 3'b001, 0, cyc);
    checkOutput("both_sp", sp_out, 16'h2FFE);
    max_wait = 2; cur_wait = 2;
    applyStimulus(1, 0, 16'h2222, 3'b010, 100, cyc);
    applyStimulus(0, 1, 16'h0000, 3'b000, 100, cyc);
    applyStimulus(0, 1, 16'h0000, 3'b000, 100, cyc);
    checkOutput("busy_ignore_sp", sp_out, SP_RESET);

    rand_wait = 1; max_wait = 2;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      do_save = (r <= 4) || (r == 9);
      do_rest = (r >= 5);
      applyStimulus(do_save, do_rest, 16'($urandom), 3'($urandom), 25, cyc);
    end

    resetDut();
    rand_wait = 0; max_wait = 0; cur_wait = 0;
    for (int i = 0; i < 128; i++)
      applyStimulus(1, 0, 16'($urandom), 3'($urandom), 0, cyc);
    checkOutput("full_sp", sp_out, STACK_LIMIT);
    applyStimulus(1, 0, 16'hDEAD, 3'b111, 0, cyc);
    checkOutput("overflow_latency", 16'(cyc), 16'd1);
    checkOutput("overflow_sp", sp_out, STACK_LIMIT);
    for (int i = 0; i < 128; i++)
      applyStimulus(0, 1, 16'h0000, 3'b000, 0, cyc);
    applyStimulus(0, 1, 16'h0000, 3'b000, 0, cyc);
    checkOutput("drained_sp", sp_out, SP_RESET);

    resetDut();
    block_addr = 16'h2FFE;
    @(negedge clk);
    save_req = 1'b1; pc_in = 16'h1234; {n_in, z_in, p_in} = 3'b001;
    modelIssue(1, 0, 16'h1234, 3'b001);
    @(negedge clk);
    save_req = 1'b0;
    waited = 0;
    while (!(mem_req && mem_addr == 16'h2FFE) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) failNow("reach_s_pc_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_mem_req", 16'(mem_req), 16'd0);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    checkOutput("abort_sp", sp_out, SP_RESET);
    checkOutput("abort_done", 16'(done), 16'd0);
    rst = 1'b0;
    exp_evt.delete(); exp_acc.delete(); model_stack.delete();
    model_sp = SP_RESET;
    block_addr = -1;
    @(negedge clk);
    checkOutput("post_abort_done", 16'({done, pc_load, psr_load}), 16'd0);
    checkOutput("post_abort_busy", 16'(busy), 16'd0);

    checkOutput("evt_drain", 16'(exp_evt.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
